// File: rtl/rename_regfile_mp_if.sv
// Bundle of the rename, commit, restore and read signals of rename_regfile_mp.
// The master side (rename/commit logic, or a bench) drives requests; the
// slave side (the register file) returns read results and the pending count.
interface rename_regfile_mp_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 32,
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int READ_PORTS     = 4,
  parameter int RENAME_PORTS   = 2,
  parameter int COMMIT_PORTS   = 2
);
  localparam int AW = $clog2(REG_COUNT);

  // Rename: mark a destination register as pending on a ROB id
  logic [RENAME_PORTS-1:0]                ren_en;
  logic [RENAME_PORTS*AW-1:0]             ren_addr;
  logic [RENAME_PORTS*ROB_ADDR_WIDTH-1:0] ren_id;

  // Commit: retire a value into the architectural state
  logic [COMMIT_PORTS-1:0]                cmt_en;
  logic [COMMIT_PORTS*AW-1:0]             cmt_addr;
  logic [COMMIT_PORTS*ROB_ADDR_WIDTH-1:0] cmt_id;
  logic [COMMIT_PORTS*DATA_WIDTH-1:0]     cmt_data;

  // Flush: drop every outstanding rename tag
  logic                                   restore;

  // Read: committed value or ROB id to wait on
  logic [READ_PORTS-1:0]                  rd_en;
  logic [READ_PORTS*AW-1:0]               rd_addr;
  logic [READ_PORTS-1:0]                  rd_is_ref;
  logic [READ_PORTS*DATA_WIDTH-1:0]       rd_data;

  logic [AW:0]                            pending_count;

  modport master (
    output ren_en, ren_addr, ren_id,
    output cmt_en, cmt_addr, cmt_id, cmt_data,
    output restore,
    output rd_en, rd_addr,
    input  rd_is_ref, rd_data, pending_count
  );

  modport slave (
    input  ren_en, ren_addr, ren_id,
    input  cmt_en, cmt_addr, cmt_id, cmt_data,
    input  restore,
    input  rd_en, rd_addr,
    output rd_is_ref, rd_data, pending_count
  );
endinterface

// File: rtl/rename_regfile_mp.sv
// Multi-port architectural register file with per-register ROB rename tags.
// Rename ports set a pending tag, commit ports write values and clear a tag
// only when the committing ROB id matches, and reads see either the committed
// value, the tag to wait on, or a same-cycle commit through the bypass.
// Register 0 is hardwired to zero and can never be renamed or written.
module rename_regfile_mp #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 32,
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int READ_PORTS     = 4,
  parameter int RENAME_PORTS   = 2,
  parameter int COMMIT_PORTS   = 2
) (
  input  logic                    clk,
  input  logic                    rst,   // synchronous, active-low
  rename_regfile_mp_if.slave      bus
);
  localparam int AW = $clog2(REG_COUNT);
  localparam int DW = DATA_WIDTH;
  localparam int RW = ROB_ADDR_WIDTH;

  // Architectural state
  logic [DW-1:0]        r_value     [REG_COUNT];
  logic [REG_COUNT-1:0] r_ref_valid;
  logic [RW-1:0]        r_ref_id    [REG_COUNT];
  logic [AW:0]          r_pending_count;

  // Next-state of the architectural state
  logic [DW-1:0]        w_value_nxt     [REG_COUNT];
  logic [REG_COUNT-1:0] w_ref_valid_nxt;
  logic [RW-1:0]        w_ref_id_nxt    [REG_COUNT];
  logic [AW:0]          w_pending_nxt;

  // Read results
  logic [READ_PORTS-1:0]    w_rd_is_ref;
  logic [READ_PORTS*DW-1:0] w_rd_data;

  // Next-state: commit values and tag clears first, then restore or renames on top
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    w_value_nxt     = r_value;
    w_ref_valid_nxt = r_ref_valid;
    w_ref_id_nxt    = r_ref_id;

    // Ascending port order lets the youngest commit win on a shared register.
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      if (bus.cmt_en[c] && (bus.cmt_addr[c*AW +: AW] != '0)) begin
        w_value_nxt[bus.cmt_addr[c*AW +: AW]] = bus.cmt_data[c*DW +: DW];
        // A stale commit (older tag) writes the value but keeps the younger tag.
        if (bus.cmt_id[c*RW +: RW] == r_ref_id[bus.cmt_addr[c*AW +: AW]]) begin
          w_ref_valid_nxt[bus.cmt_addr[c*AW +: AW]] = 1'b0;
        end
      end
    end

    // Renames are applied after commit clears so a rename always wins.
    if (bus.restore) begin
      w_ref_valid_nxt = '0;
    end else begin
      for (int p = 0; p < RENAME_PORTS; p++) begin
        if (bus.ren_en[p] && (bus.ren_addr[p*AW +: AW] != '0)) begin
          w_ref_valid_nxt[bus.ren_addr[p*AW +: AW]] = 1'b1;
          w_ref_id_nxt[bus.ren_addr[p*AW +: AW]]    = bus.ren_id[p*RW +: RW];
        end
      end
    end
  end

  // Popcount of next-state tags so the registered count tracks ref_valid exactly
  always_comb begin
    w_pending_nxt = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      w_pending_nxt = w_pending_nxt + (AW+1)'(w_ref_valid_nxt[r]);
    end
  end

  // State update with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the value array is reset explicitly because a reset must drop
      // all committed values, not only the tags; this costs a reset on every
      // storage bit.
      for (int r = 0; r < REG_COUNT; r++) begin
        r_value[r]  <= '0;
        r_ref_id[r] <= '0;
      end
      r_ref_valid     <= '0;
      r_pending_count <= '0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        r_value[r]  <= w_value_nxt[r];
        r_ref_id[r] <= w_ref_id_nxt[r];
      end
      r_value[0]      <= '0;
      r_ref_id[0]     <= '0;
      r_ref_valid     <= w_ref_valid_nxt;
      r_pending_count <= w_pending_nxt;
    end
  end

  // Combinational read: disabled/r0 -> 0, commit bypass -> data, tag -> id, else value
  always_comb begin
    w_rd_is_ref = '0;
    w_rd_data   = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (bus.rd_en[p] && (bus.rd_addr[p*AW +: AW] != '0)) begin
        if (r_ref_valid[bus.rd_addr[p*AW +: AW]]) begin
          w_rd_is_ref[p]          = 1'b1;
          w_rd_data[p*DW +: DW]   = DW'(r_ref_id[bus.rd_addr[p*AW +: AW]]);
          // Ascending order leaves the highest matching commit port in place.
          for (int c = 0; c < COMMIT_PORTS; c++) begin
            if (bus.cmt_en[c] &&
                (bus.cmt_addr[c*AW +: AW] == bus.rd_addr[p*AW +: AW]) &&
                (bus.cmt_id[c*RW +: RW] == r_ref_id[bus.rd_addr[p*AW +: AW]])) begin
              w_rd_is_ref[p]        = 1'b0;
              w_rd_data[p*DW +: DW] = bus.cmt_data[c*DW +: DW];
            end
          end
        end else begin
          w_rd_data[p*DW +: DW] = r_value[bus.rd_addr[p*AW +: AW]];
        end
      end
    end
  end

  assign bus.rd_is_ref     = w_rd_is_ref;
  assign bus.rd_data       = w_rd_data;
  assign bus.pending_count = r_pending_count;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed bench for rename_regfile_mp: reset, commit, rename, bypass,
// stale commit, rename-over-commit, restore, register 0 and mid-run reset.
module tb_rename_regfile_mp;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_COUNT      = 32;
  localparam int ROB_ADDR_WIDTH = 4;
  localparam int READ_PORTS     = 4;
  localparam int RENAME_PORTS   = 2;
  localparam int COMMIT_PORTS   = 2;
  localparam int AW = $clog2(REG_COUNT);
  localparam int DW = DATA_WIDTH;
  localparam int RW = ROB_ADDR_WIDTH;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rename_regfile_mp_if #(
    .DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT), .ROB_ADDR_WIDTH(ROB_ADDR_WIDTH),
    .READ_PORTS(READ_PORTS), .RENAME_PORTS(RENAME_PORTS), .COMMIT_PORTS(COMMIT_PORTS)
  ) bus ();

  rename_regfile_mp #(
    .DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT), .ROB_ADDR_WIDTH(ROB_ADDR_WIDTH),
    .READ_PORTS(READ_PORTS), .RENAME_PORTS(RENAME_PORTS), .COMMIT_PORTS(COMMIT_PORTS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int p, input logic exp_ref, input logic [DW-1:0] exp_data);
    check({tag, "_isref"}, 64'(bus.rd_is_ref[p]), 64'(exp_ref));
    check({tag, "_data"},  64'(bus.rd_data[p*DW +: DW]), 64'(exp_data));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    check({tag, "_cnt"}, 64'(bus.pending_count), 64'(exp));
  endtask

  task automatic idle();
    bus.ren_en   = '0;
    bus.ren_addr = '0;
    bus.ren_id   = '0;
    bus.cmt_en   = '0;
    bus.cmt_addr = '0;
    bus.cmt_id   = '0;
    bus.cmt_data = '0;
    bus.restore  = 1'b0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic ren(input int p, input int addr, input int id);
    bus.ren_en[p]            = 1'b1;
    bus.ren_addr[p*AW +: AW] = AW'(addr);
    bus.ren_id[p*RW +: RW]   = RW'(id);
  endtask

  task automatic cmt(input int p, input int addr, input int id, input logic [DW-1:0] data);
    bus.cmt_en[p]            = 1'b1;
    bus.cmt_addr[p*AW +: AW] = AW'(addr);
    bus.cmt_id[p*RW +: RW]   = RW'(id);
    bus.cmt_data[p*DW +: DW] = data;
  endtask

  task automatic rd(input int p, input int addr);
    bus.rd_en[p]            = 1'b1;
    bus.rd_addr[p*AW +: AW] = AW'(addr);
  endtask

  // One clock edge, then return at the falling edge with idle inputs.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state
    rd(0, 1); rd(1, 0); #1;
    chk_rd("rst_r1", 0, 1'b0, 32'h0);
    chk_rd("rst_r0", 1, 1'b0, 32'h0);
    chk_cnt("rst", 0);

    // 1. plain commit
    cmt(0, 1, 0, 32'h12345678); cycle();
    rd(0, 1); #1;
    chk_rd("t1_r1", 0, 1'b0, 32'h12345678);
    chk_cnt("t1", 0);

    // 2. rename, then matching commit with bypass (highest port wins)
    ren(0, 1, 'hA); cycle();
    rd(0, 1); rd(3, 1); #1;
    chk_rd("t2_ref", 0, 1'b1, 32'h0000000A);
    chk_cnt("t2_ref", 1);
    cmt(0, 1, 'hA, 32'h44); cmt(1, 1, 'hA, 32'h55); #1;
    chk_rd("t2_byp0", 0, 1'b0, 32'h55);
    chk_rd("t2_byp3", 3, 1'b0, 32'h55);
    cycle();
    rd(0, 1); #1;
    chk_rd("t2_after", 0, 1'b0, 32'h55);
    chk_cnt("t2_after", 0);

    // 3. rename and stale commit on the same register in the same cycle
    ren(0, 2, 'hF); cmt(0, 2, 'h3, 32'hABCDEF00); cycle();
    rd(0, 2); #1;
    chk_rd("t3_ref", 0, 1'b1, 32'h0000000F);
    chk_cnt("t3_ref", 1);
    bus.restore = 1'b1; cycle();
    rd(0, 2); #1;
    chk_rd("t3_val", 0, 1'b0, 32'hABCDEF00);
    chk_cnt("t3_val", 0);

    // 4. two renames to one register, stale commit, then matching commit
    ren(0, 5, 'h2); ren(1, 5, 'h7); cycle();
    rd(0, 5); #1;
    chk_rd("t4_ref", 0, 1'b1, 32'h7);
    chk_cnt("t4_ref", 1);
    cmt(0, 5, 'h2, 32'h1111); #1;
    chk_rd("t4_nobyp", 0, 1'b1, 32'h7);
    cycle();
    rd(0, 5); #1;
    chk_rd("t4_stale", 0, 1'b1, 32'h7);
    chk_cnt("t4_stale", 1);
    cmt(0, 5, 'h7, 32'h2222); cycle();
    rd(0, 5); #1;
    chk_rd("t4_done", 0, 1'b0, 32'h2222);
    chk_cnt("t4_done", 0);

    // 5. restore discards tags and same-cycle renames, keeps commit values
    ren(0, 3, 'h1); ren(1, 4, 'h2); cycle();
    rd(0, 3); rd(1, 4); #1;
    chk_rd("t5_r3", 0, 1'b1, 32'h1);
    chk_rd("t5_r4", 1, 1'b1, 32'h2);
    chk_cnt("t5_pre", 2);
    bus.restore = 1'b1; ren(0, 6, 'h5); cmt(0, 3, 'h9, 32'h3333); cycle();
    rd(0, 3); rd(1, 4); rd(2, 6); #1;
    chk_rd("t5_r3_post", 0, 1'b0, 32'h3333);
    chk_rd("t5_r4_post", 1, 1'b0, 32'h0);
    chk_rd("t5_r6_post", 2, 1'b0, 32'h0);
    chk_cnt("t5_post", 0);

    // Rename beats a matching commit clear on the same register
    ren(0, 7, 'h1); cycle();
    cmt(0, 7, 'h1, 32'h7777); ren(1, 7, 'h4); cycle();
    rd(0, 7); #1;
    chk_rd("rbc_ref", 0, 1'b1, 32'h4);
    chk_cnt("rbc_ref", 1);
    bus.restore = 1'b1; cycle();
    rd(0, 7); #1;
    chk_rd("rbc_val", 0, 1'b0, 32'h7777);
    chk_cnt("rbc_val", 0);

    // 6. register 0 ignores rename/commit; rd_en=0 returns zero
    ren(0, 0, 'h3); ren(1, 8, 'h6); cmt(0, 0, 'h0, 32'hFFFF); cycle();
    rd(0, 0); rd(1, 8); bus.rd_en[1] = 1'b0; rd(2, 8); #1;
    chk_rd("t6_r0", 0, 1'b0, 32'h0);
    chk_rd("t6_dis", 1, 1'b0, 32'h0);
    chk_rd("t6_r8", 2, 1'b1, 32'h6);
    chk_cnt("t6_r0", 1);

    // Mid-run reset drops all tags and values, overriding same-cycle requests
    rst = 1'b0; ren(0, 9, 'h2); cmt(0, 10, 'h0, 32'hBEEF); cycle();
    rst = 1'b1;
    rd(0, 8); rd(1, 1); rd(2, 9); rd(3, 2); #1;
    chk_rd("rst2_r8", 0, 1'b0, 32'h0);
    chk_rd("rst2_r1", 1, 1'b0, 32'h0);
    chk_rd("rst2_r9", 2, 1'b0, 32'h0);
    chk_rd("rst2_r2", 3, 1'b0, 32'h0);
    chk_cnt("rst2", 0);
    idle(); rd(0, 10); #1;
    chk_rd("rst2_r10", 0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
